// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//   Shares one combinational ALU between two requesters. A round-robin grant
//   is issued from IDLE, the winning operation is latched and driven to the
//   ALU for one EXEC cycle, and the result is held in RESP until the consumer
//   takes it. Only one operation is ever in flight.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   reqN_valid / reqN_ready         requester N handshake (ready is
//                                   combinational, only ever high in IDLE)
//   reqN_A, reqN_B, reqN_ctrl,      operands, ALU op code and flag-update
//   reqN_setf                       enable of requester N
//   alu_A, alu_B, alu_ctrl          registered drive to the shared ALU
//   alu_Y, alu_CO, alu_OVF,         combinational ALU result and flags
//   alu_Z, alu_N
//   rsp_valid, rsp_id, rsp_Y        response to the requester rsp_id
//   rsp_ready                       consumer accepts the response
//   flag_N, flag_Z, flag_C, flag_V  architectural flag register
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req0_A,
    input  logic [WIDTH-1:0] req0_B,
    input  logic [WIDTH-1:0] req1_A,
    input  logic [WIDTH-1:0] req1_B,
    input  logic [2:0]       req0_ctrl,
    input  logic [2:0]       req1_ctrl,
    input  logic             req0_setf,
    input  logic             req1_setf,

    output logic [WIDTH-1:0] alu_A,
    output logic [WIDTH-1:0] alu_B,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_Y,
    input  logic             alu_CO,
    input  logic             alu_OVF,
    input  logic             alu_Z,
    input  logic             alu_N,

    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_Y,
    input  logic             rsp_ready,

    output logic             flag_N,
    output logic             flag_Z,
    output logic             flag_C,
    output logic             flag_V
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   grant0, grant1;
    logic   last_grant;   // id of the most recent grant
    logic   setf_q;       // latched flag-update enable of the op in flight

    // Next state and grant decision. With both requesters valid the one not
    // granted last wins; a lone requester always wins.
    always_comb begin
        state_nxt = state;
        grant0    = 1'b0;
        grant1    = 1'b0;
        case (state)
            IDLE: begin
                if (req0_valid && (!req1_valid || last_grant))
                    grant0 = 1'b1;
                else if (req1_valid)
                    grant1 = 1'b1;
                if (grant0 || grant1)
                    state_nxt = EXEC;
            end
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Ready is combinational from the grant; masked while reset is held so no
    // handshake can complete during reset.
    assign req0_ready = grant0 & rst_n;
    assign req1_ready = grant1 & rst_n;
    assign rsp_valid  = (state == RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Operation latch, result capture and flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_A      <= '0;
            alu_B      <= '0;
            alu_ctrl   <= 3'b000;
            setf_q     <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_Y      <= '0;
            last_grant <= 1'b1;   // requester 0 wins the first contested grant
            flag_N     <= 1'b0;
            flag_Z     <= 1'b0;
            flag_C     <= 1'b0;
            flag_V     <= 1'b0;
        end else begin
            if (grant0 || grant1) begin
                alu_A      <= grant1 ? req1_A    : req0_A;
                alu_B      <= grant1 ? req1_B    : req0_B;
                alu_ctrl   <= grant1 ? req1_ctrl : req0_ctrl;
                setf_q     <= grant1 ? req1_setf : req0_setf;
                rsp_id     <= grant1;
                last_grant <= grant1;
            end
            if (state == EXEC) begin
                rsp_Y <= alu_Y;
                if (setf_q) begin
                    flag_N <= alu_N;
                    flag_Z <= alu_Z;
                    // Carry and overflow are only meaningful for add/sub
                    // (op codes 000..010); logic ops leave them untouched.
                    if (alu_ctrl < 3'd3) begin
                        flag_C <= alu_CO;
                        flag_V <= alu_OVF;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//   Bench for alu_arbiter. Provides the shared ALU as a behavioural function,
//   keeps a transaction-level reference model of the arbiter, and compares
//   every cycle's outputs against it, plus directed constant checks.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         req0_valid, req1_valid, req0_ready, req1_ready;
    logic [W-1:0] req0_A, req0_B, req1_A, req1_B;
    logic [2:0]   req0_ctrl, req1_ctrl;
    logic         req0_setf, req1_setf;
    logic [W-1:0] alu_A, alu_B, alu_Y;
    logic [2:0]   alu_ctrl;
    logic         alu_CO, alu_OVF, alu_Z, alu_N;
    logic         rsp_valid, rsp_id, rsp_ready;
    logic [W-1:0] rsp_Y;
    logic         flag_N, flag_Z, flag_C, flag_V;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_A(req0_A), .req0_B(req0_B), .req1_A(req1_A), .req1_B(req1_B),
        .req0_ctrl(req0_ctrl), .req1_ctrl(req1_ctrl),
        .req0_setf(req0_setf), .req1_setf(req1_setf),
        .alu_A(alu_A), .alu_B(alu_B), .alu_ctrl(alu_ctrl),
        .alu_Y(alu_Y), .alu_CO(alu_CO), .alu_OVF(alu_OVF), .alu_Z(alu_Z), .alu_N(alu_N),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_Y(rsp_Y), .rsp_ready(rsp_ready),
        .flag_N(flag_N), .flag_Z(flag_Z), .flag_C(flag_C), .flag_V(flag_V)
    );

    // Shared ALU: returns {Y, CO, OVF, Z, N}. Carry is "no borrow" for subtracts.
    function automatic logic [W+3:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [2:0] op);
        logic [W:0]   s;
        logic [W-1:0] y;
        logic         co, ov;
        s  = '0;
        ov = 1'b0;
        case (op)
            3'd0: begin
                s  = {1'b0, a} + {1'b0, b};
                ov = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
            end
            3'd1: begin
                s  = {1'b0, a} + {1'b0, ~b} + 33'd1;
                ov = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
            end
            3'd2: begin
                s  = {1'b0, b} + {1'b0, ~a} + 33'd1;
                ov = (a[W-1] != b[W-1]) && (s[W-1] != b[W-1]);
            end
            3'd3:    s = {1'b0, a & ~b};
            3'd4:    s = {1'b0, a & b};
            3'd5:    s = {1'b0, a | b};
            3'd6:    s = {1'b0, a ^ b};
            default: s = {1'b0, ~(a ^ b)};
        endcase
        y  = s[W-1:0];
        co = (op < 3'd3) ? s[W] : 1'b0;
        return {y, co, ov, (y == '0), y[W-1]};
    endfunction

    always_comb {alu_Y, alu_CO, alu_OVF, alu_Z, alu_N} = alu_fn(alu_A, alu_B, alu_ctrl);

    // Reference model: phase of the op in flight (0 none, 1 executing,
    // 2 awaiting consumer), plus what the outputs must show.
    int           m_phase;
    logic         m_last, m_setf, m_id;
    logic [W-1:0] m_A, m_B, m_Y;
    logic [2:0]   m_ctrl;
    logic [3:0]   m_flags;   // {N,Z,C,V}
    logic         gq[$];     // grant order

    logic         snap_r0, snap_r1, snap_rv, snap_id;
    logic [W-1:0] snap_y;
    logic [3:0]   snap_fl;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] act_vec(input bit mask);
        logic         id;
        logic [W-1:0] y;
        id = mask ? 1'b0 : rsp_id;
        y  = mask ? '0   : rsp_Y;
        return 128'({req0_ready, req1_ready, rsp_valid, id, y, alu_A, alu_B, alu_ctrl,
                     flag_N, flag_Z, flag_C, flag_V});
    endfunction

    function automatic logic [127:0] exp_vec();
        logic         r0, r1, rv, id;
        logic [W-1:0] y;
        r0 = rst_n && (m_phase == 0) && req0_valid && (!req1_valid || m_last);
        r1 = rst_n && (m_phase == 0) && req1_valid && !r0;
        rv = (m_phase == 2);
        id = rv ? m_id : 1'b0;
        y  = rv ? m_Y  : '0;
        return 128'({r0, r1, rv, id, y, m_A, m_B, m_ctrl, m_flags});
    endfunction

    task automatic model_reset();
        m_phase = 0; m_last = 1'b1; m_setf = 1'b0; m_id = 1'b0;
        m_A = '0; m_B = '0; m_Y = '0; m_ctrl = 3'd0; m_flags = 4'd0;
    endtask

    // Called just after a negedge with inputs already driven. Checks, then
    // advances the model across the following rising edge.
    task automatic cycle(input string tag);
        logic [W+3:0] r;
        logic         g;
        #1;
        chk(tag, act_vec(m_phase != 2), exp_vec());
        snap_r0 = req0_ready; snap_r1 = req1_ready; snap_rv = rsp_valid;
        snap_id = rsp_id;     snap_y  = rsp_Y;
        snap_fl = {flag_N, flag_Z, flag_C, flag_V};
        @(posedge clk);
        case (m_phase)
            0: if (req0_valid || req1_valid) begin
                g = (req0_valid && (!req1_valid || m_last)) ? 1'b0 : 1'b1;
                m_A    = g ? req1_A    : req0_A;
                m_B    = g ? req1_B    : req0_B;
                m_ctrl = g ? req1_ctrl : req0_ctrl;
                m_setf = g ? req1_setf : req0_setf;
                m_id = g; m_last = g; m_phase = 1;
                gq.push_back(g);
            end
            1: begin
                r   = alu_fn(m_A, m_B, m_ctrl);
                m_Y = r[W+3:4];
                if (m_setf) begin
                    m_flags[3] = r[0];
                    m_flags[2] = r[1];
                    if (m_ctrl inside {3'd0, 3'd1, 3'd2}) begin
                        m_flags[1] = r[3];
                        m_flags[0] = r[2];
                    end
                end
                m_phase = 2;
            end
            default: if (rsp_ready) m_phase = 0;
        endcase
        @(negedge clk);
    endtask

    // Called just after a negedge: asserts reset mid-cycle, checks outputs
    // asynchronously, releases on the next negedge.
    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        chk("reset_values", act_vec(1'b0), 128'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drive(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] op, input bit setf);
        if (id) begin
            req1_valid = 1'b1; req1_A = a; req1_B = b; req1_ctrl = op; req1_setf = setf;
        end else begin
            req0_valid = 1'b1; req0_A = a; req0_B = b; req0_ctrl = op; req0_setf = setf;
        end
    endtask

    task automatic run_op(input string tag, input bit id, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [2:0] op, input bit setf);
        rsp_ready = 1'b1;
        drive(id, a, b, op, setf);
        cycle({tag, "_grant"});
        req0_valid = 1'b0; req1_valid = 1'b0;
        cycle({tag, "_exec"});
        cycle({tag, "_resp"});
    endtask

    function automatic logic [W-1:0] rand_opnd();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    logic [W+1:0] held;
    logic [3:0]   order;

    initial begin
        req0_valid = 0; req1_valid = 0; rsp_ready = 0;
        req0_A = '0; req0_B = '0; req1_A = '0; req1_B = '0;
        req0_ctrl = '0; req1_ctrl = '0; req0_setf = 0; req1_setf = 0;
        model_reset();
        @(negedge clk);
        apply_reset();

        // 5 - 3 from requester 0
        rsp_ready = 1'b1;
        drive(0, 32'd5, 32'd3, 3'b001, 1'b1);
        cycle("sub_t0");
        chk("sub_ready0", 128'({snap_r0, snap_r1}), 128'(2'b10));
        req0_valid = 1'b0;
        cycle("sub_t1");
        chk("sub_no_rsp_t1", 128'(snap_rv), 128'(1'b0));
        cycle("sub_t2");
        chk("sub_rsp", 128'({snap_rv, snap_id, snap_y}), 128'({1'b1, 1'b0, 32'd2}));
        chk("sub_flags", 128'(snap_fl), 128'(4'b0010));
        cycle("sub_t3");
        chk("sub_rsp_drop", 128'(snap_rv), 128'(1'b0));

        // overflowing add, then xor with C/V retained
        run_op("add_ovf", 0, 32'h7FFF_FFFF, 32'h1, 3'b000, 1'b1);
        chk("add_ovf_y", 128'(snap_y), 128'(32'h8000_0000));
        chk("add_ovf_flags", 128'(snap_fl), 128'(4'b1001));
        run_op("xor_z", 1, 32'hFF, 32'hFF, 3'b110, 1'b1);
        chk("xor_z_flags", 128'(snap_fl), 128'(4'b0101));
        run_op("or_nosetf", 0, 32'h8000_0000, 32'h0, 3'b101, 1'b0);
        chk("nosetf_flags", 128'(snap_fl), 128'(4'b0101));

        // reset in the middle of EXEC
        drive(0, 32'h7FFF_FFFF, 32'h1, 3'b000, 1'b1);
        cycle("rst_exec_grant");
        req0_valid = 1'b0;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            cycle("rst_exec_idle");
            chk("rst_exec_no_rsp", 128'({snap_rv, snap_fl}), 128'd0);
        end

        // both requesters valid continuously: alternating grants from 0
        gq.delete();
        rsp_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive(0, $urandom, $urandom, 3'($urandom_range(0, 7)), 1'b1);
            drive(1, $urandom, $urandom, 3'($urandom_range(0, 7)), 1'b1);
            cycle("rr_cycle");
            chk("rr_exclusive", 128'(snap_r0 & snap_r1), 128'd0);
        end
        chk("rr_grant_count", 128'(gq.size() >= 4), 128'd1);
        order = 4'b1111;
        for (int i = 0; i < 4 && i < gq.size(); i++) order[3-i] = gq[i];
        chk("rr_order", 128'(order), 128'(4'b0101));

        req0_valid = 0; req1_valid = 0;
        for (int i = 0; i < 8 && m_phase != 0; i++) cycle("drain");
        chk("drain_idle", 128'(m_phase == 0), 128'd1);

        // consumer stalls for 4 cycles while requester 1 waits
        rsp_ready = 1'b0;
        drive(0, 32'h1234, 32'h0F0F, 3'b011, 1'b0);
        drive(1, 32'h1, 32'h2, 3'b000, 1'b1);
        cycle("stall_grant");
        chk("stall_grant0", 128'({snap_r0, snap_r1}), 128'(2'b10));
        req0_valid = 1'b0;
        cycle("stall_exec");
        chk("stall_exec_r1", 128'(snap_r1), 128'd0);
        held = {1'b1, 1'b0, 32'h1234 & ~32'h0F0F};
        for (int i = 0; i < 4; i++) begin
            cycle("stall_resp");
            chk("stall_hold", 128'({snap_rv, snap_id, snap_y}), 128'(held));
            chk("stall_r1_low", 128'(snap_r1), 128'd0);
        end
        rsp_ready = 1'b1;
        cycle("stall_accept");
        chk("stall_accept_r1", 128'({snap_rv, snap_r1}), 128'(2'b10));
        cycle("stall_regrant");
        chk("stall_grant1", 128'({snap_rv, snap_r1}), 128'(2'b01));
        req1_valid = 1'b0;

        // randomized traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            req0_valid = ($urandom_range(0, 2) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_A = rand_opnd(); req0_B = rand_opnd();
            req1_A = rand_opnd(); req1_B = rand_opnd();
            req0_ctrl = 3'($urandom_range(0, 7)); req1_ctrl = 3'($urandom_range(0, 7));
            req0_setf = 1'($urandom); req1_setf = 1'($urandom);
            rsp_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 199) == 0) apply_reset();
            cycle("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of operands, result and ALU ports.
REQ-002 SHALL have clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have req0_valid / req1_valid  input  1 each  requester n presents an operation.
REQ-005 SHALL have req0_ready / req1_ready  output  1 each  operation from requester n accepted this cycle.
REQ-006 SHALL have req0_A, req0_B, req1_A, req1_B  input  WIDTH each  operands.
REQ-007 SHALL have req0_ctrl / req1_ctrl  input  3 each  ALU op code: 000 add, 001 A-B, 010 B-A, 011 A&~B, 100 and, 101 or, 110 xor, 111 xnor.
REQ-008 SHALL have req0_setf / req1_setf  input  1 each  operation updates the flag register.
REQ-009 SHALL have alu_A, alu_B  output  WIDTH each, and alu_ctrl  output  3  registered drive to the shared ALU.
REQ-010 SHALL have alu_Y  input  WIDTH, and alu_CO, alu_OVF, alu_Z, alu_N  input  1 each  combinational ALU result and flags.
REQ-011 SHALL have rsp_valid  output  1, rsp_id  output  1, rsp_Y  output  WIDTH  result returned to the requester identified by rsp_id.
REQ-012 SHALL have rsp_ready  input  1  consumer accepts the response.
REQ-013 SHALL have flag_N, flag_Z, flag_C, flag_V  output  1 each  architectural flag register.

Function
REQ-014 SHALL implement states IDLE, EXEC, RESP; one operation in flight at a time.
REQ-015 IDLE: if no reqN_valid, SHALL remain IDLE with both ready low.
REQ-016 IDLE with valid present: SHALL grant exactly one requester, assert its reqN_ready combinationally in that cycle, latch its A, B, ctrl, setf and id, and move to EXEC.
REQ-017 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; with one valid, grant it regardless of history; last-grant updates only on a grant.
REQ-018 reqN_ready SHALL never be high outside IDLE and never high for both requesters in the same cycle.
REQ-019 alu_A, alu_B, alu_ctrl SHALL be driven from the latched registers and hold stable from EXEC entry until the next grant.
REQ-020 EXEC (exactly one cycle): SHALL capture alu_Y into rsp_Y, and SHALL move to RESP.
REQ-021 In EXEC with latched setf=1: flag_N<=alu_N and flag_Z<=alu_Z for all ops; flag_C<=alu_CO and flag_V<=alu_OVF only for ctrl 000, 001, 010; for ctrl 011-111, C and V SHALL hold their previous values.
REQ-022 In EXEC with setf=0, all four flags SHALL hold.
REQ-023 RESP: rsp_valid SHALL be 1 with rsp_id and rsp_Y stable until the cycle rsp_ready=1; that cycle SHALL return to IDLE with rsp_valid low next cycle.
REQ-024 Latency: grant at cycle t, rsp_valid high at t+2; minimum issue interval 3 cycles (back-to-back requests with rsp_ready tied high).
REQ-025 rsp_ready while not in RESP SHALL be ignored; requester inputs changing while not granted SHALL have no effect.

Reset
REQ-026 On rst_n low, state SHALL go to IDLE immediately regardless of clk.
REQ-027 Reset values: req0_ready=0, req1_ready=0 (in reset), rsp_valid=0, rsp_id=0, rsp_Y=0, alu_A=0, alu_B=0, alu_ctrl=000, all four flags=0, last-grant=1 (requester 0 wins the first contested grant).
REQ-028 Reset during EXEC or RESP SHALL discard the operation: no flag update, no response delivered.

Verification
REQ-029 Only req0 valid, A=5, B=3, ctrl=001, setf=1, rsp_ready=1 -> ready0 at t, rsp_valid at t+2, rsp_id=0, rsp_Y=2, N=0 Z=0 C=1 V=0.
REQ-030 Both valid continuously out of reset, rsp_ready=1 -> grants in order 0,1,0,1; ready never high for both; each response id matches grant.
REQ-031 Add 0x7FFFFFFF+1 setf=1 then xor A=B=0xFF setf=1 -> after add N=1 V=1 C=0 Z=0; after xor Z=1 N=0, C=0 and V=1 retained.
REQ-032 Response with rsp_ready low for 4 cycles, req1 valid meanwhile -> rsp_valid, rsp_Y, rsp_id stable 4 cycles, ready1 stays 0 until return to IDLE, then granted.
REQ-033 rst_n pulsed low mid-EXEC of an op with setf=1 -> outputs at reset values asynchronously, flags remain 0, no rsp_valid afterwards until a new grant.
